// File: rtl/trig_gen.sv
// Ultrasonic ranging trigger sequencer: emits the sensor trigger pulse, waits for the echo
// receiver to report completion (or time out), then enforces a hold-off before re-arming.
module trig_gen #(
  parameter int unsigned TRIG_CYCLES    = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 3800000,
  parameter int unsigned HOLDOFF_CYCLES = 2000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        auto_en,
  input  logic        echo,
  input  logic        e_done,
  output logic        trig,
  output logic        i_idle,
  output logic        busy,
  output logic        timeout,
  output logic [15:0] meas_cnt
);

  localparam logic [31:0] TrigLast    = 32'(TRIG_CYCLES - 1);
  localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] HoldLast    = 32'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StTrig, StWait, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [15:0] meas_cnt_q, meas_cnt_d;
  logic        trig_q, trig_d;
  logic        i_idle_q, i_idle_d;
  logic        timeout_q, timeout_d;

  always_comb begin
    state_d    = state_q;
    meas_cnt_d = meas_cnt_q;
    timeout_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (start || auto_en) state_d = StTrig;
      end
      StTrig: begin
        if (cnt_q == TrigLast) state_d = StWait;
      end
      StWait: begin
        // A completion on the last wait cycle wins over the timeout.
        if (e_done) begin
          state_d    = StHold;
          meas_cnt_d = meas_cnt_q + 16'd1;
        end else if (cnt_q == TimeoutLast) begin
          state_d   = StHold;
          timeout_d = 1'b1;
        end
      end
      StHold: begin
        if ((cnt_q >= HoldLast) && !echo) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Counter restarts on every state entry; in hold it parks once the minimum gap is met.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == StIdle) begin
      cnt_d = '0;
    end else if ((state_q == StHold) && (cnt_q >= HoldLast)) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end

    trig_d   = (state_d == StTrig);
    i_idle_d = (state_q == StHold) && (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      meas_cnt_q <= '0;
      trig_q     <= 1'b0;
      i_idle_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      meas_cnt_q <= meas_cnt_d;
      trig_q     <= trig_d;
      i_idle_q   <= i_idle_d;
      timeout_q  <= timeout_d;
    end
  end

  assign trig     = trig_q;
  assign i_idle   = i_idle_q;
  assign timeout  = timeout_q;
  assign busy     = (state_q != StIdle);
  assign meas_cnt = meas_cnt_q;

endmodule

// File: doc/trig_gen.md
TRIG_GEN -- requirements
Module: trig_gen

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Parameter TRIG_CYCLES, default 1000: trigger pulse width in clk cycles (10 us at 100 MHz); legal range 1 or more.
REQ-003 Parameter TIMEOUT_CYCLES, default 3800000: maximum wait for echo completion after the trigger falls; legal range 2 or more.
REQ-004 Parameter HOLDOFF_CYCLES, default 2000000: minimum gap after a measurement ends before the next trigger may start; legal range 1 or more.
REQ-005 Port clk, input, 1 bit: system clock.
REQ-006 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 Port start, input, 1 bit: single-shot measurement request, sampled only in IDLE.
REQ-008 Port auto_en, input, 1 bit: continuous mode; while high, each return to IDLE retriggers.
REQ-009 Port echo, input, 1 bit: raw sensor echo line, already synchronised.
REQ-010 Port e_done, input, 1 bit: one-cycle pulse from the echo-width receiver marking a completed measurement.
REQ-011 Port trig, output, 1 bit: trigger line to the sensor.
REQ-012 Port i_idle, output, 1 bit: one-cycle pulse telling the receiver to clear its state.
REQ-013 Port busy, output, 1 bit: high in every state other than IDLE.
REQ-014 Port timeout, output, 1 bit: one-cycle pulse when the echo wait expires.
REQ-015 Port meas_cnt, output, 16 bits: count of accepted e_done pulses.

Function
REQ-016 The block SHALL implement four states: IDLE, TRIG, WAIT, HOLD. A single 32-bit counter SHALL be cleared to 0 on every state entry.
REQ-017 IDLE: if start or auto_en is 1, the block SHALL go to TRIG on the next edge. Both high together SHALL act as one request.
REQ-018 trig SHALL be registered and high exactly in the TRIG state, giving exactly TRIG_CYCLES consecutive high cycles. The first high cycle SHALL be the cycle after the request was sampled.
REQ-019 TRIG SHALL exit to WAIT when the counter equals TRIG_CYCLES-1.
REQ-020 WAIT, in priority order:
- e_done = 1: go to HOLD, increment meas_cnt.
- Otherwise, counter equals TIMEOUT_CYCLES-1: pulse timeout for one cycle, go to HOLD.
REQ-021 If e_done and the timeout condition occur in the same cycle, the block SHALL treat it as success: no timeout pulse, meas_cnt increments.
REQ-022 meas_cnt SHALL wrap from 0xFFFF to 0x0000 without any flag.
REQ-023 HOLD SHALL last at least HOLDOFF_CYCLES cycles. It SHALL exit to IDLE at the first cycle where the counter is at least HOLDOFF_CYCLES-1 and echo is 0. While echo stays high, the counter SHALL saturate rather than wrap.
REQ-024 On the HOLD-to-IDLE transition, i_idle SHALL be high for exactly one cycle, coincident with the first IDLE cycle.
REQ-025 start, auto_en and e_done SHALL be ignored in TRIG and HOLD. start SHALL also be ignored in WAIT.
REQ-026 Deasserting auto_en mid-measurement SHALL let the current measurement complete normally; no retrigger follows.
REQ-027 A minimum cycle period SHALL follow from the above:
- Success path: TRIG_CYCLES + 1 + HOLDOFF_CYCLES cycles from trig rise to i_idle.
- Timeout path: TRIG_CYCLES + TIMEOUT_CYCLES + HOLDOFF_CYCLES cycles from trig rise to i_idle.

Reset
REQ-028 While rst_n is 0, the block SHALL hold: state IDLE, counter 0, trig 0, i_idle 0, busy 0, timeout 0, meas_cnt 0.
REQ-029 Reset asserted mid-operation, including mid-trigger, SHALL drop trig immediately (asynchronously). After release, the block SHALL be in IDLE with no i_idle pulse.
REQ-030 After rst_n deasserts, the first request SHALL be honoured on the first rising clock edge.

Verification
All scenarios use TRIG_CYCLES=4, TIMEOUT_CYCLES=20, HOLDOFF_CYCLES=8.
REQ-031 Single-shot success: start pulse 1 cycle, then e_done 5 cycles after trig falls. Required: trig high exactly 4 cycles; meas_cnt 0 to 1; no timeout; i_idle pulses 8 cycles after HOLD entry; busy falls with it.
REQ-032 Timeout: start, no e_done. Required: timeout pulses on WAIT cycle 20; meas_cnt stays 0; i_idle pulses 8 cycles later.
REQ-033 Collision: e_done on the same cycle as WAIT counter 19. Required: no timeout pulse; meas_cnt increments.
REQ-034 Echo stuck: echo held high through HOLD for 15 cycles. Required: HOLD extends until echo falls, then IDLE plus i_idle on the following edge.
REQ-035 Auto mode with wrap: auto_en=1 and a preloaded meas_cnt of 0xFFFF, or 65536 runs. Required: back-to-back triggers separated by HOLD; meas_cnt reads 0x0000 after the wrap; start pulses while busy have no effect.
REQ-036 Reset during TRIG, on cycle 2. Required: trig is 0 before the next clk edge; all outputs are 0 after release; no i_idle pulse.
